vga_coord_fetch: RTL and testbench
==================================

Name:
vga_coord_fetch

Overview:
- Fetches the six per-frame sprite coordinates (monkey x/y, platform1 x/y, platform2 x/y) from data memory once per frame.
- Presents them to the VGA bit generator as an indexed word stream on vga_counter / data_from_mem_vga.
- Sits between the memory arbiter (VGA read port) and the bit generator. Triggered by the frame pulse from vga_control.
- All six words are fetched into shadow registers before any are presented, so a frame never mixes old and new positions.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory word width; equals the coordinate width (CORDW).
- BASE_ADDR, 16'hFFF0, address of the first coordinate word; words are consecutive.
- N_WORDS, 6, number of coordinate words; vga_counter index = word number + 1.
- MAX_WAIT, 255, maximum cycles to wait for mem_gnt per word before aborting.

Ports:
- clk  in  1  pixel-domain clock (clk_25MHz in bit_gen).
- rst  in  1  asynchronous, active-high reset.
- fetch_start  in  1  one-cycle pulse; connect to vga_control frame.
- mem_req  out  1  read request to arbiter.
- mem_addr  out  ADDR_W  read address, valid while mem_req.
- mem_gnt  in  1  arbiter accepts request this cycle.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after the mem_req&&mem_gnt cycle.
- vga_counter  out  3  word index 1..N_WORDS during commit; 0 otherwise.
- data_from_mem_vga  out  DATA_W  word for the current vga_counter index.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse after a successful commit.
- err_overrun  out  1  sticky: fetch_start arrived while not IDLE.
- err_timeout  out  1  sticky: mem_gnt wait exceeded MAX_WAIT.
- err_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; word index=0; wait counter=0; shadow regs=0.
  - All outputs 0: mem_req, mem_addr, vga_counter, data_from_mem_vga, busy, done, both error flags.
- All outputs are registered.
- FSM states: IDLE, REQ, CAPT, COMMIT, DONE.
- IDLE: fetch_start=1 -> REQ with idx=0.
- REQ:
  - mem_req=1, mem_addr=BASE_ADDR+idx.
  - mem_gnt=1 -> CAPT.
  - Otherwise increment the wait counter; at MAX_WAIT with no grant, set err_timeout and go to IDLE.
  - On abort: no commit, vga_counter stays 0, shadow contents are discarded.
- CAPT:
  - mem_req=0; shadow[idx]<=mem_rdata; wait counter cleared.
  - idx==N_WORDS-1 -> COMMIT with idx=0; else idx+1 and -> REQ.
- COMMIT:
  - Output vga_counter=idx+1 and data_from_mem_vga=shadow[idx] together in the same register update, one word per cycle.
  - Indices 1..6 appear on consecutive cycles, each for exactly one cycle.
  - After index N_WORDS -> DONE.
- DONE: vga_counter=0, done=1 for one cycle -> IDLE.
- data_from_mem_vga holds its last value whenever vga_counter=0.
- Latency with mem_gnt tied high:
  - fetch_start sampled in cycle 0 gives REQ in cycles 1,3,...,11 and CAPT in 2,...,12.
  - vga_counter=1..6 in cycles 13..18; done in cycle 19.
- Overrun:
  - fetch_start in any non-IDLE state (including DONE) sets err_overrun and is ignored.
  - The fetch in progress continues unaffected.
- err_clr:
  - Clears both flags.
  - If err_clr and a new error occur in the same cycle, the error wins and the flag stays 1.
- Address arithmetic is modulo 2^ADDR_W (BASE_ADDR+idx wraps).
- Reset mid-fetch or mid-commit: immediate return to IDLE with all outputs 0. Words already committed remain in bit_gen's latches.

Decomposition:
- Shared package vga_pkg holds CORDW, the FSM state encoding, and the vga_counter index constants (IDX_MX=1, IDX_MY=2, IDX_P1X=3, IDX_P1Y=4, IDX_P2X=5, IDX_P2Y=6).
- One natural sub-module, coord_shadow_regs: N_WORDS x DATA_W write-indexed register file with an indexed read mux.

Test Plan:
- Memory 0xFFF0..0xFFF5 = 0x0010,0x0020,0x0030,0x0040,0x0050,0x0060; mem_gnt=1; fetch_start pulse -> mem_addr FFF0..FFF5 in cycles 1,3,...,11; vga_counter 1..6 in cycles 13..18 with data 0x0010..0x0060; done in cycle 19.
- Arbiter grants the second word only after 3 stall cycles -> mem_req and mem_addr=0xFFF1 held steady for 4 cycles; commit delayed by 3 cycles; data still correct.
- mem_gnt=0 permanently -> err_timeout=1 after MAX_WAIT cycles in REQ; state IDLE; vga_counter never leaves 0; no done pulse.
- Second fetch_start in cycle 5 of a fetch -> err_overrun=1; original sequence completes unchanged; err_clr pulse then drives err_overrun to 0.
- Assert rst during COMMIT at vga_counter=3 -> all outputs 0 in the same cycle; a later fetch_start runs a complete, correct sequence.
- BASE_ADDR=16'hFFFD -> addresses FFFD, FFFE, FFFF, 0000, 0001, 0002 (wrap).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA coordinate fetch path: coordinate width, fetch FSM
// encoding and the vga_counter index assignments seen by the bit generator.
package vga_pkg;

  localparam int unsigned CORDW = 16;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StCapt,
    StCommit,
    StDone
  } fetch_state_e;

  localparam logic [IDX_W-1:0] IDX_MX  = 3'd1;
  localparam logic [IDX_W-1:0] IDX_MY  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_P1X = 3'd3;
  localparam logic [IDX_W-1:0] IDX_P1Y = 3'd4;
  localparam logic [IDX_W-1:0] IDX_P2X = 3'd5;
  localparam logic [IDX_W-1:0] IDX_P2Y = 3'd6;

endpackage

// File: rtl/coord_shadow_regs.sv
// Write-indexed shadow register file holding one frame of coordinates, with an
// indexed combinational read port.
module coord_shadow_regs
  import vga_pkg::*;
#(
  parameter int unsigned N_WORDS = 6,
  parameter int unsigned DATA_W  = CORDW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs_q [N_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_WORDS; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (waddr == IDX_W'(i)) regs_q[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      if (raddr == IDX_W'(i)) rdata = regs_q[i];
    end
  end

endmodule

// File: rtl/vga_coord_fetch.sv
// Fetches one frame's sprite coordinates into shadow registers, then streams them to
// the bit generator as (vga_counter, data_from_mem_vga) pairs, one word per cycle.
module vga_coord_fetch
  import vga_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = CORDW,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFFF0,
  parameter int unsigned       N_WORDS   = 6,
  parameter int unsigned       MAX_WAIT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [IDX_W-1:0]  vga_counter,
  output logic [DATA_W-1:0] data_from_mem_vga,
  output logic              busy,
  output logic              done,
  output logic              err_overrun,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int unsigned      WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  fetch_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [IDX_W-1:0]  vga_counter_q, vga_counter_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              tmo_q, tmo_d;

  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] shadow_rdata;

  // Outputs are registered, so the read index looks one word ahead of idx_q.
  assign rd_idx = (state_q == StCommit) ? idx_q + IDX_W'(1) : '0;

  coord_shadow_regs #(
    .N_WORDS (N_WORDS),
    .DATA_W  (DATA_W)
  ) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .we    (state_q == StCapt),
    .waddr (idx_q),
    .wdata (mem_rdata),
    .raddr (rd_idx),
    .rdata (shadow_rdata)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_d        = wait_q;
    mem_req_d     = 1'b0;
    mem_addr_d    = mem_addr_q;
    vga_counter_d = '0;
    data_d        = data_q;
    done_d        = 1'b0;
    // A new error in the same cycle as err_clr leaves the flag set.
    ovr_d         = (ovr_q & ~err_clr) | (fetch_start & (state_q != StIdle));
    tmo_d         = tmo_q & ~err_clr;

    unique case (state_q)
      StIdle: begin
        if (fetch_start) begin
          state_d    = StReq;
          idx_d      = '0;
          wait_d     = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = BASE_ADDR;
        end
      end
      StReq: begin
        if (mem_gnt) begin
          state_d = StCapt;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = StIdle;
          wait_d  = '0;
          tmo_d   = 1'b1;
        end else begin
          wait_d    = wait_q + WAIT_W'(1);
          mem_req_d = 1'b1;
        end
      end
      StCapt: begin
        wait_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d       = StCommit;
          idx_d         = '0;
          vga_counter_d = rd_idx + IDX_MX;
          data_d        = shadow_rdata;
        end else begin
          state_d    = StReq;
          idx_d      = idx_q + IDX_W'(1);
          mem_req_d  = 1'b1;
          mem_addr_d = BASE_ADDR + ADDR_W'(idx_q) + ADDR_W'(1);
        end
      end
      StCommit: begin
        if (idx_q == LAST_IDX) begin
          state_d = StDone;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d         = rd_idx;
          vga_counter_d = rd_idx + IDX_MX;
          data_d        = shadow_rdata;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      wait_q        <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      vga_counter_q <= '0;
      data_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ovr_q         <= 1'b0;
      tmo_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      vga_counter_q <= vga_counter_d;
      data_q        <= data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ovr_q         <= ovr_d;
      tmo_q         <= tmo_d;
    end
  end

  assign mem_req           = mem_req_q;
  assign mem_addr          = mem_addr_q;
  assign vga_counter       = vga_counter_q;
  assign data_from_mem_vga = data_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err_overrun       = ovr_q;
  assign err_timeout       = tmo_q;

endmodule

// File: tb/tb_vga_coord_fetch.sv
// Self-checking bench for vga_coord_fetch: per-cycle table for the no-stall frame,
// hand-written corner sequences, and randomized arbiter stalls against a frame model.
module tb_vga_coord_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_start, mem_req, mem_gnt = 1'b0, busy, done;
  logic        err_overrun, err_timeout, err_clr;
  logic [15:0] mem_addr, mem_rdata, data_from_mem_vga;
  logic [2:0]  vga_counter;

  logic        fs2, req2, gnt2, busy2, done2, ovr2, tmo2, clr2;
  logic [15:0] addr2, rdata2, d2;
  logic [2:0]  vc2;

  always #5 clk = ~clk;

  vga_coord_fetch u_dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_start       (fetch_start),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_gnt           (mem_gnt),
    .mem_rdata         (mem_rdata),
    .vga_counter       (vga_counter),
    .data_from_mem_vga (data_from_mem_vga),
    .busy              (busy),
    .done              (done),
    .err_overrun       (err_overrun),
    .err_timeout       (err_timeout),
    .err_clr           (err_clr)
  );

  vga_coord_fetch #(
    .BASE_ADDR (16'hFFFD)
  ) u_dut_wrap (
    .clk               (clk),
    .rst               (rst),
    .fetch_start       (fs2),
    .mem_req           (req2),
    .mem_addr          (addr2),
    .mem_gnt           (gnt2),
    .mem_rdata         (rdata2),
    .vga_counter       (vc2),
    .data_from_mem_vga (d2),
    .busy              (busy2),
    .done              (done2),
    .err_overrun       (ovr2),
    .err_timeout       (tmo2),
    .err_clr           (clr2)
  );

  // Memory and arbiter model.
  logic [15:0] mem [65536];
  int          gnt_mode = 0;  // 0 always, 1 never, 2 random, 3 stall 0xFFF1 three cycles
  int          stall_seen = 0;

  always begin
    @(posedge clk);
    #1;
    case (gnt_mode)
      0: mem_gnt = 1'b1;
      1: mem_gnt = 1'b0;
      2: mem_gnt = ($urandom_range(0, 2) != 0);
      default: begin
        if (mem_req && mem_addr == 16'hFFF1) begin
          mem_gnt = (stall_seen >= 3);
          stall_seen++;
        end else begin
          mem_gnt = 1'b1;
        end
      end
    endcase
  end

  always @(posedge clk) begin
    mem_rdata <= (mem_req && mem_gnt) ? mem[mem_addr] : 16'($urandom);
    rdata2    <= req2 ? mem[addr2] : 16'($urandom);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_outs(input string tag);
    chk($sformatf("%s mem_req", tag), mem_req, 0);
    chk($sformatf("%s mem_addr", tag), mem_addr, 0);
    chk($sformatf("%s vga_counter", tag), vga_counter, 0);
    chk($sformatf("%s data", tag), data_from_mem_vga, 0);
    chk($sformatf("%s busy", tag), busy, 0);
    chk($sformatf("%s done", tag), done, 0);
    chk($sformatf("%s err_overrun", tag), err_overrun, 0);
    chk($sformatf("%s err_timeout", tag), err_timeout, 0);
  endtask

  // Frame observations, relative to the cycle in which fetch_start is sampled.
  int          cq_vc[$];
  int          cq_cyc[$];
  logic [15:0] cq_d[$];
  logic [15:0] aq[$];

  task automatic run_fetch(input int fs_at1, input int fs_at2, input int clr_at,
                           output int done_cyc, output int stalls, output int hold);
    cq_vc.delete(); cq_cyc.delete(); cq_d.delete(); aq.delete();
    done_cyc = -1; stalls = 0; hold = 0;
    @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk);
    for (int c = 1; c < 800; c++) begin
      fetch_start = 1'b0;
      err_clr = 1'b0;
      if (vga_counter != 0) begin
        cq_vc.push_back(int'(vga_counter)); cq_d.push_back(data_from_mem_vga);
        cq_cyc.push_back(c);
      end
      if (mem_req && mem_gnt) aq.push_back(mem_addr);
      if (mem_req && !mem_gnt) stalls++;
      if (mem_req && mem_addr == 16'hFFF1) hold++;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (c == fs_at1 || c == fs_at2) fetch_start = 1'b1;
      if (c == clr_at) err_clr = 1'b1;
      @(negedge clk);
    end
    fetch_start = 1'b0;
    err_clr = 1'b0;
  endtask

  // Frame model: word i comes from base+i (16-bit wrap), shown as index i+1; the frame
  // takes two cycles per word plus stalls, then N_WORDS commit cycles, then done.
  task automatic check_frame(input string tag, input logic [15:0] base, input int done_cyc,
                             input int stalls);
    int          exp_done;
    logic [15:0] a;
    exp_done = 2 * 6 + stalls + 6 + 1;
    chk($sformatf("%s done cycle", tag), done_cyc, exp_done);
    chk($sformatf("%s commit count", tag), cq_vc.size(), 6);
    chk($sformatf("%s grant count", tag), aq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      a = base + 16'(i);
      if (i < aq.size()) chk($sformatf("%s addr[%0d]", tag, i), aq[i], a);
      if (i < cq_vc.size()) begin
        chk($sformatf("%s index[%0d]", tag, i), cq_vc[i], i + 1);
        chk($sformatf("%s data[%0d]", tag, i), cq_d[i], mem[a]);
        chk($sformatf("%s commit cycle[%0d]", tag, i), cq_cyc[i], exp_done - 6 + i);
      end
    end
  endtask

  typedef struct {
    logic        fs;
    logic        req;
    logic [15:0] addr;
    logic [2:0]  vc;
    logic [15:0] data;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int          dc, st, hold, hit, req_cnt, vc_seen, done_seen, first_tmo, done2_cyc;
    logic [15:0] a;
    logic [15:0] aq2[$];
    logic [15:0] dq2[$];

    fetch_start = 1'b0; err_clr = 1'b0; fs2 = 1'b0; clr2 = 1'b0; gnt2 = 1'b1;

    for (int c = 0; c < 21; c++) begin
      tbl[c].fs   = (c == 0);
      tbl[c].req  = (c >= 1 && c <= 11 && (c % 2) == 1);
      tbl[c].addr = 16'hFFF0 + 16'((c - 1) / 2);
      tbl[c].vc   = (c >= 13 && c <= 18) ? 3'(c - 12) : 3'd0;
      tbl[c].data = (c < 13) ? 16'h0000 : ((c <= 18) ? 16'(16 * (c - 12)) : 16'h0060);
      tbl[c].done = (c == 19);
      tbl[c].busy = (c >= 1 && c <= 19);
    end
    for (int i = 0; i < 6; i++) mem[16'hFFF0 + i] = 16'(16 * (i + 1));

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    idle_outs("reset");
    chk("reset wrap req", req2, 0);
    chk("reset wrap vc", vc2, 0);
    rst = 1'b0;

    // No-stall frame, cycle by cycle.
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      chk($sformatf("tbl[%0d] mem_req", c), mem_req, tbl[c].req);
      if (tbl[c].req) chk($sformatf("tbl[%0d] mem_addr", c), mem_addr, tbl[c].addr);
      chk($sformatf("tbl[%0d] vga_counter", c), vga_counter, tbl[c].vc);
      chk($sformatf("tbl[%0d] data", c), data_from_mem_vga, tbl[c].data);
      chk($sformatf("tbl[%0d] done", c), done, tbl[c].done);
      chk($sformatf("tbl[%0d] busy", c), busy, tbl[c].busy);
      fetch_start = tbl[c].fs;
    end
    fetch_start = 1'b0;

    // Second word granted after three stall cycles.
    gnt_mode = 3; stall_seen = 0;
    for (int i = 0; i < 6; i++) mem[16'hFFF0 + i] = 16'h0A00 + 16'(i * 17);
    run_fetch(-1, -1, -1, dc, st, hold);
    check_frame("stall", 16'hFFF0, dc, 3);
    chk("stall count", st, 3);
    chk("stall FFF1 hold", hold, 4);

    // Overrun mid-fetch, then err_clr colliding with another overrun.
    gnt_mode = 0;
    run_fetch(5, 8, 8, dc, st, hold);
    check_frame("overrun", 16'hFFF0, dc, 0);
    chk("overrun flag", err_overrun, 1);
    chk("overrun no timeout", err_timeout, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("overrun cleared", err_overrun, 0);

    // Permanent grant starvation.
    gnt_mode = 1;
    @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    req_cnt = 0; vc_seen = 0; done_seen = 0; first_tmo = -1;
    for (int c = 1; c <= 300; c++) begin
      if (mem_req) req_cnt++;
      if (vga_counter != 0) vc_seen++;
      if (done) done_seen++;
      if (err_timeout && first_tmo < 0) first_tmo = c;
      @(negedge clk);
    end
    chk("timeout req cycles", req_cnt, 255);
    chk("timeout flag cycle", first_tmo, 256);
    chk("timeout flag", err_timeout, 1);
    chk("timeout busy", busy, 0);
    chk("timeout vga_counter seen", vc_seen, 0);
    chk("timeout done seen", done_seen, 0);
    gnt_mode = 0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("timeout cleared", err_timeout, 0);

    // Reset while vga_counter=3, then a clean frame.
    for (int i = 0; i < 6; i++) mem[16'hFFF0 + i] = 16'($urandom);
    @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && hit == 0; c++) begin
      if (vga_counter == 3'd3) hit = 1;
      else @(negedge clk);
    end
    chk("rst mid commit reached", hit, 1);
    rst = 1'b1;
    #1;
    idle_outs("rst mid commit");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) mem[16'hFFF0 + i] = 16'($urandom);
    run_fetch(-1, -1, -1, dc, st, hold);
    check_frame("after rst", 16'hFFF0, dc, 0);

    // Random arbiter stalls against the frame model.
    gnt_mode = 2;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 6; i++) mem[16'hFFF0 + i] = 16'($urandom);
      run_fetch(-1, -1, -1, dc, st, hold);
      check_frame($sformatf("rand%0d", k), 16'hFFF0, dc, st);
    end
    gnt_mode = 0;

    // Address wrap from BASE_ADDR=0xFFFD.
    for (int i = 0; i < 6; i++) begin
      a = 16'hFFFD + 16'(i);
      mem[a] = 16'($urandom);
    end
    done2_cyc = -1;
    @(negedge clk);
    fs2 = 1'b1;
    @(negedge clk);
    fs2 = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (req2) aq2.push_back(addr2);
      if (vc2 != 0) dq2.push_back(d2);
      if (done2 && done2_cyc < 0) done2_cyc = c;
      @(negedge clk);
    end
    chk("wrap addr count", aq2.size(), 6);
    chk("wrap commit count", dq2.size(), 6);
    chk("wrap done cycle", done2_cyc, 19);
    for (int i = 0; i < 6; i++) begin
      a = 16'hFFFD + 16'(i);
      if (i < aq2.size()) chk($sformatf("wrap addr[%0d]", i), aq2[i], a);
      if (i < dq2.size()) chk($sformatf("wrap data[%0d]", i), dq2[i], mem[a]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
